// File: rtl/iv_bus_mem.sv
// ============================================================================
//  Module      : iv_bus_mem
//  Description : Multi-bank command-driven memory. Each bank owns a private
//                address register and storage array. sc loads an address,
//                wc writes data, and an idle command on an enabled bank reads
//                the lowest-index enabled bank with one-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iv_bus_mem #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int BANKS    = 2,
   parameter int AUTO_INC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sc,
   input  logic              wc,
   input  logic [BANKS-1:0]  n_bank_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] addr_out,
   output logic              cmd_err
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

   logic [ADDR_W-1:0] addr_q [BANKS];
   logic [ADDR_W-1:0] addr_d [BANKS];
   logic [DATA_W-1:0] mem_q  [BANKS][DEPTH];

   logic [DATA_W-1:0] dout_q,     dout_d;
   logic              rd_valid_q, rd_valid_d;
   logic              cmd_err_q,  cmd_err_d;

   logic [BANK_W-1:0] rd_bank;
   logic [DATA_W-1:0] rd_data;
   logic              any_en;
   logic              do_load;
   logic              do_write;
   logic              do_read;
   logic              collide;

   // Command decode: with no bank enabled every command is a no-op.
   always_comb begin
      any_en   = |(~n_bank_en);
      do_load  = sc & any_en;
      do_write = wc & ~sc & any_en;
      do_read  = ~sc & ~wc & any_en;
      collide  = sc & wc & any_en;
   end

   // Lowest-index enabled bank; falls back to bank 0 when none is enabled.
   always_comb begin
      rd_bank = '0;
      for (int b = BANKS - 1; b >= 0; b--) begin
         if (!n_bank_en[b]) begin
            rd_bank = BANK_W'(b);
         end
      end
   end

   // Read data and address view both follow the selected bank.
   always_comb begin
      rd_data  = mem_q[rd_bank][addr_q[rd_bank]];
      addr_out = addr_q[rd_bank];
   end

   // Per-bank address next state: load wins, otherwise optional post-increment
   // of the banks touched by this access (all enabled on write, rd_bank on read).
   always_comb begin
      for (int b = 0; b < BANKS; b++) begin
         addr_d[b] = addr_q[b];
         if (!n_bank_en[b]) begin
            if (do_load) begin
               addr_d[b] = din[ADDR_W-1:0];
            end else if ((AUTO_INC != 0) && do_write) begin
               addr_d[b] = addr_q[b] + ADDR_W'(1);
            end else if ((AUTO_INC != 0) && do_read && (rd_bank == BANK_W'(b))) begin
               addr_d[b] = addr_q[b] + ADDR_W'(1);
            end
         end
      end
   end

   // Output register next state: dout holds between reads, cmd_err is sticky.
   always_comb begin
      dout_d     = do_read ? rd_data : dout_q;
      rd_valid_d = do_read;
      cmd_err_d  = cmd_err_q | collide;
   end

   // Address registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < BANKS; b++) begin
            addr_q[b] <= '0;
         end
      end else begin
         addr_q <= addr_d;
      end
   end

   // Storage arrays are never cleared; writes are blocked while reset is high.
   always_ff @(posedge clk) begin
      if (!reset && do_write) begin
         for (int b = 0; b < BANKS; b++) begin
            if (!n_bank_en[b]) begin
               mem_q[b][addr_q[b]] <= din;
            end
         end
      end
   end

   // Output registers with synchronous reset; reset also cancels a pending read.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         dout_q     <= dout_d;
         rd_valid_q <= rd_valid_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   assign dout     = dout_q;
   assign rd_valid = rd_valid_q;
   assign cmd_err  = cmd_err_q;

endmodule

`default_nettype wire

// File: doc/iv_bus_mem.md
IV_BUS_MEM -- requirements
Module: iv_bus_mem

Interface
- REQ-001: Parameter DATA_W, default 8, sets the data word width.
- REQ-002: Parameter ADDR_W, default 8, sets the address width; each bank holds 2^ADDR_W words.
- REQ-003: Parameter BANKS, default 2, sets the bank count; bank 0 is the left bank and bank 1 is the right bank.
- REQ-004: Parameter AUTO_INC, default 0, enables post-increment of a bank's address after each data access when set to 1.
- REQ-005: Port clk, input, 1 bit, is the single clock; all state SHALL update on the rising edge.
- REQ-006: Port reset, input, 1 bit, is a synchronous active-high reset.
- REQ-007: Port sc, input, 1 bit, is the select command: it loads an address.
- REQ-008: Port wc, input, 1 bit, is the write command: it writes data.
- REQ-009: Port n_bank_en, input, BANKS bits, holds active-low per-bank enables.
- REQ-010: Port din, input, DATA_W bits, carries write data, and carries the address in its low ADDR_W bits during sc.
- REQ-011: Port dout, output, DATA_W bits, is the registered read data.
- REQ-012: Port rd_valid, output, 1 bit, pulses high for one cycle when dout carries new read data.
- REQ-013: Port addr_out, output, ADDR_W bits, shows the current address register of the lowest-index enabled bank, or bank 0 when no bank is enabled.
- REQ-014: Port cmd_err, output, 1 bit, is a sticky command-collision flag.

Function
- REQ-015: Each bank SHALL own a private ADDR_W-bit address register and a DATA_W x 2^ADDR_W storage array.
- REQ-016: A cycle with sc=1 and wc=0 SHALL load din[ADDR_W-1:0] into the address register of every enabled bank (broadcast).
- REQ-017: A cycle with wc=1 and sc=0 SHALL write din to mem[b][addr[b]] for every enabled bank b.
- REQ-018: A read cycle is sc=0, wc=0 with at least one bank enabled.
  - It SHALL register mem[k][addr[k]] into dout, where k is the lowest-index enabled bank.
  - It SHALL set rd_valid=1 on the following cycle, giving one-cycle latency.
- REQ-019: rd_valid SHALL be 0 in every cycle that does not follow a read cycle; dout SHALL hold its last value when no read occurs.
- REQ-020: With AUTO_INC=1, every wc write and every read SHALL increment the address register of each accessed bank by 1, wrapping from 2^ADDR_W-1 to 0.
  - The accessed banks are all enabled banks for a write, and bank k only for a read.
- REQ-021: With AUTO_INC=0, address registers SHALL change only on sc or reset.
- REQ-022: sc=1 and wc=1 in the same cycle with any bank enabled:
  - the address load SHALL take effect;
  - the write SHALL be suppressed;
  - cmd_err SHALL be set to 1 from the next cycle until reset.
- REQ-023: A cycle with all n_bank_en bits high SHALL change no state except clearing rd_valid, whatever sc and wc are.
- REQ-024: A read issued in the cycle after a write to the same location SHALL return the newly written data.
- REQ-025: Banks SHALL be fully independent: an access to bank b SHALL NOT alter the address or data of any other bank.

Reset
- REQ-026: While reset=1 at a rising edge, all address registers, dout, rd_valid and cmd_err SHALL become 0, and sc, wc and read activity in that cycle SHALL be ignored.
- REQ-027: Storage array contents SHALL NOT be cleared by reset and SHALL persist across it.
- REQ-028: A reset asserted between a read cycle and its rd_valid cycle SHALL cancel the read: rd_valid=0 and dout=0.

Verification
- REQ-029: Scenario 1, defaults: enable bank 0; sc with din=0x12; wc with din=0xA5; one read cycle -> dout=0xA5 with rd_valid=1 exactly one cycle after the read; addr_out=0x12 throughout.
- REQ-030: Scenario 2, bank isolation: enable bank 1 only; sc 0x12; wc 0x3C; then enable bank 0 only and read -> dout=0xA5 (bank 1 did not corrupt bank 0); re-read bank 1 -> 0x3C.
- REQ-031: Scenario 3, AUTO_INC=1: sc 0xFE; wc 0x01, 0x02, 0x03 -> mem[0xFE]=0x01, mem[0xFF]=0x02, mem[0x00]=0x03, final addr_out=0x01.
- REQ-032: Scenario 4, collision: sc=1, wc=1, din=0x40, bank 0 enabled -> addr_out=0x40, mem[0x40] unchanged, cmd_err=1 next cycle and still 1 ten cycles later, 0 after reset.
- REQ-033: Scenario 5, broadcast: both banks enabled; sc 0x07; wc 0x99; read each bank separately -> both return 0x99.
- REQ-034: Scenario 6, reset mid-read: read cycle then reset=1 next cycle -> rd_valid=0, dout=0, addr_out=0; a later read of the old address after a new sc returns the pre-reset data.
